// File: rtl/hamming_cost_wta.sv
`timescale 1ns/1ps
// hamming_cost_wta
//   Census-transform matching cost with winner-take-all disparity selection.
//   For each accepted beat the reference census code is XORed with every
//   disparity candidate, the differences are popcounted, and a binary tree of
//   registered pairwise-minimum stages picks the lowest-cost candidate.
//   Latency is 2 + clog2(NUM_DISP) cycles. The whole pipeline advances as
//   one unit whenever ready_in is high and holds otherwise.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   census_left   reference census code
//   census_right  NUM_DISP candidate codes, candidate d at [d*CENSUS_WIDTH +: CENSUS_WIDTH]
//   cfg_max_cost  acceptance threshold, travels with the beat
//   valid_in      input beat offered
//   ready_in      beat accepted this cycle (!valid_out || ready_out)
//   valid_out     result beat valid
//   ready_out     downstream accepts result
//   best_disp     index of the minimum-cost candidate
//   min_cost      Hamming distance of best_disp
//   disp_reject   min_cost exceeds the beat's cfg_max_cost
module hamming_cost_wta #(
  parameter int CENSUS_WIDTH = 24,
  parameter int NUM_DISP     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CENSUS_WIDTH-1:0]               census_left,
  input  logic [NUM_DISP*CENSUS_WIDTH-1:0]      census_right,
  input  logic [$clog2(CENSUS_WIDTH+1)-1:0]     cfg_max_cost,
  input  logic                                  valid_in,
  output logic                                  ready_in,
  output logic                                  valid_out,
  input  logic                                  ready_out,
  output logic [$clog2(NUM_DISP)-1:0]           best_disp,
  output logic [$clog2(CENSUS_WIDTH+1)-1:0]     min_cost,
  output logic                                  disp_reject
);

  localparam int COST_WIDTH = $clog2(CENSUS_WIDTH + 1);
  localparam int DISP_WIDTH = $clog2(NUM_DISP);

  function automatic logic [COST_WIDTH-1:0] popcount(input logic [CENSUS_WIDTH-1:0] v);
    logic [COST_WIDTH-1:0] n;
    n = '0;
    for (int b = 0; b < CENSUS_WIDTH; b++) n = n + COST_WIDTH'(v[b]);
    return n;
  endfunction

  // Single global advance: output slot free or being drained.
  assign ready_in = !valid_out || ready_out;

  // Stage 1: per-candidate difference vectors.
  logic [CENSUS_WIDTH-1:0] xor_q [NUM_DISP];
  logic                    s1_valid;
  logic [COST_WIDTH-1:0]   s1_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cfg   <= '0;
      for (int d = 0; d < NUM_DISP; d++) xor_q[d] <= '0;
    end else if (ready_in) begin
      s1_valid <= valid_in;
      s1_cfg   <= cfg_max_cost;
      for (int d = 0; d < NUM_DISP; d++)
        xor_q[d] <= census_left ^ census_right[d*CENSUS_WIDTH +: CENSUS_WIDTH];
    end
  end

  // Stage 2: exact popcounts; COST_WIDTH holds CENSUS_WIDTH without overflow.
  logic [COST_WIDTH-1:0] cost_s2 [NUM_DISP];
  logic                  s2_valid;
  logic [COST_WIDTH-1:0] s2_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_cfg   <= '0;
      for (int d = 0; d < NUM_DISP; d++) cost_s2[d] <= '0;
    end else if (ready_in) begin
      s2_valid <= s1_valid;
      s2_cfg   <= s1_cfg;
      for (int d = 0; d < NUM_DISP; d++) cost_s2[d] <= popcount(xor_q[d]);
    end
  end

  // Minimum tree: level lv halves the candidate count. Entry 2j always covers
  // lower disparity indices than entry 2j+1, so keeping the even entry on a
  // tie yields the lowest index among equal minima.
  for (genvar lv = 0; lv < DISP_WIDTH; lv++) begin : g_lvl
    localparam int N = NUM_DISP >> (lv + 1);

    logic [COST_WIDTH-1:0] in_cost [2*N];
    logic [DISP_WIDTH-1:0] in_idx  [2*N];
    logic                  in_valid;
    logic [COST_WIDTH-1:0] in_cfg;

    logic [COST_WIDTH-1:0] win_cost [N];
    logic [DISP_WIDTH-1:0] win_idx  [N];

    logic [COST_WIDTH-1:0] cost_q [N];
    logic [DISP_WIDTH-1:0] idx_q  [N];
    logic                  valid_q;

    if (lv == 0) begin : g_src
      always_comb begin
        in_valid = s2_valid;
        in_cfg   = s2_cfg;
        for (int i = 0; i < 2*N; i++) begin
          in_cost[i] = cost_s2[i];
          in_idx[i]  = DISP_WIDTH'(i);
        end
      end
    end else begin : g_src
      always_comb begin
        in_valid = g_lvl[lv-1].valid_q;
        in_cfg   = g_lvl[lv-1].g_mid.cfg_q;
        for (int i = 0; i < 2*N; i++) begin
          in_cost[i] = g_lvl[lv-1].cost_q[i];
          in_idx[i]  = g_lvl[lv-1].idx_q[i];
        end
      end
    end

    always_comb begin
      for (int j = 0; j < N; j++) begin
        if (in_cost[2*j+1] < in_cost[2*j]) begin
          win_cost[j] = in_cost[2*j+1];
          win_idx[j]  = in_idx[2*j+1];
        end else begin
          win_cost[j] = in_cost[2*j];
          win_idx[j]  = in_idx[2*j];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        for (int j = 0; j < N; j++) begin
          cost_q[j] <= '0;
          idx_q[j]  <= '0;
        end
      end else if (ready_in) begin
        valid_q <= in_valid;
        for (int j = 0; j < N; j++) begin
          cost_q[j] <= win_cost[j];
          idx_q[j]  <= win_idx[j];
        end
      end
    end

    // The last level turns the threshold into the registered reject flag;
    // earlier levels just carry the threshold along with the beat.
    if (lv == DISP_WIDTH - 1) begin : g_end
      logic reject_q;
      always_ff @(posedge clk) begin
        if (rst)           reject_q <= 1'b0;
        else if (ready_in) reject_q <= (win_cost[0] > in_cfg);
      end
    end else begin : g_mid
      logic [COST_WIDTH-1:0] cfg_q;
      always_ff @(posedge clk) begin
        if (rst)           cfg_q <= '0;
        else if (ready_in) cfg_q <= in_cfg;
      end
    end
  end

  assign valid_out   = g_lvl[DISP_WIDTH-1].valid_q;
  assign best_disp   = g_lvl[DISP_WIDTH-1].idx_q[0];
  assign min_cost    = g_lvl[DISP_WIDTH-1].cost_q[0];
  assign disp_reject = g_lvl[DISP_WIDTH-1].g_end.reject_q;

endmodule

// File: tb/tb_hamming_cost_wta.sv
`timescale 1ns/1ps
// Bench for hamming_cost_wta at CENSUS_WIDTH=8, NUM_DISP=4 (latency 4).
module tb_hamming_cost_wta;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  census_left;
  logic [31:0] census_right;
  logic [3:0]  cfg_max_cost;
  logic        valid_in;
  logic        ready_in;
  logic        valid_out;
  logic        ready_out;
  logic [1:0]  best_disp;
  logic [3:0]  min_cost;
  logic        disp_reject;

  hamming_cost_wta #(.CENSUS_WIDTH(8), .NUM_DISP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .census_left  (census_left),
    .census_right (census_right),
    .cfg_max_cost (cfg_max_cost),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .best_disp    (best_disp),
    .min_cost     (min_cost),
    .disp_reject  (disp_reject)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] disp;
    logic [3:0] cost;
    logic       rej;
    int         acc;
    logic       lat;
  } beat_t;

  beat_t q[$];
  int    cyc = 0;
  logic  mon_en = 1'b0;
  logic  bp_mode = 1'b0;
  logic  lat_mode = 1'b0;
  logic  front_shown = 1'b0;
  int    vo_run = 0;
  int    max_run = 0;
  logic [1:0] exp_disp;
  logic [3:0] exp_cost;
  logic       exp_rej;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bp_mode) ready_out = 1'($urandom_range(0, 1));
  end

  // Scoreboard at mid-cycle: every valid output cycle is compared against
  // the oldest outstanding beat, which also catches outputs moving while stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        vo_run++;
        if (vo_run > max_run) max_run = vo_run;
        if (q.size() == 0) begin
          check_val("stale_beat", 32'(valid_out), 0);
        end else begin
          check_val("best_disp", 32'(best_disp), 32'(q[0].disp));
          check_val("min_cost", 32'(min_cost), 32'(q[0].cost));
          check_val("disp_reject", 32'(disp_reject), 32'(q[0].rej));
          if (q[0].lat && !front_shown) check_val("latency", 32'(cyc - q[0].acc), LAT);
          front_shown = 1'b1;
          if (ready_out) begin
            void'(q.pop_front());
            front_shown = 1'b0;
          end
        end
      end else begin
        vo_run = 0;
      end
      if (rst) begin
        q.delete();
        front_shown = 1'b0;
      end else if (valid_in && ready_in) begin
        q.push_back('{exp_disp, exp_cost, exp_rej, cyc, lat_mode});
      end
    end
  end

  function automatic void model(input logic [7:0] l, input logic [31:0] r, input logic [3:0] c,
                                output logic [1:0] d, output logic [3:0] cost, output logic rj);
    logic [3:0] best;
    logic [7:0] x;
    logic [3:0] pc;
    best = 4'd15;
    d = 2'd0;
    for (int k = 0; k < 4; k++) begin
      x = l ^ r[k*8 +: 8];
      pc = 4'd0;
      for (int b = 0; b < 8; b++) pc = pc + {3'b000, x[b]};
      if (pc < best) begin
        best = pc;
        d = 2'(k);
      end
    end
    cost = best;
    rj = (best > c);
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send(input logic [7:0] l, input logic [31:0] r, input logic [3:0] c,
                      input logic [1:0] ed, input logic [3:0] ec, input logic er);
    int tries;
    tries = 0;
    exp_disp = ed;
    exp_cost = ec;
    exp_rej  = er;
    census_left  = l;
    census_right = r;
    cfg_max_cost = c;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && tries < 200) begin
      tries++;
      @(negedge clk);
    end
    if (!ready_in) check_val("send_timeout", 32'(ready_in), 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (q.size() != 0 && tries < 300) begin
      tries++;
      @(negedge clk);
    end
    check_val("drain", 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  l;
    logic [31:0] r;
    logic [3:0]  c;
    logic [1:0]  md;
    logic [3:0]  mc;
    logic        mr;

    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b1;
    census_left = '0;
    census_right = '0;
    cfg_max_cost = '0;
    exp_disp = '0;
    exp_cost = '0;
    exp_rej = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_valid_out", 32'(valid_out), 0);
    check_val("rst_best_disp", 32'(best_disp), 0);
    check_val("rst_min_cost", 32'(min_cost), 0);
    check_val("rst_disp_reject", 32'(disp_reject), 0);
    check_val("rst_ready_in", 32'(ready_in), 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, expected values worked out by hand.
    lat_mode = 1'b1;
    send(8'h55, 32'hFF0055AA, 4'd8, 2'd1, 4'd0, 1'b0);  // exact match at d=1
    send(8'hF0, 32'hF8F4F2F1, 4'd8, 2'd0, 4'd1, 1'b0);  // four-way tie -> d=0
    send(8'hFF, 32'h01F00F00, 4'd3, 2'd1, 4'd4, 1'b1);  // tie d=1/d=2, cost 4 > 3
    send(8'hF0, 32'hF200F10F, 4'd1, 2'd1, 4'd1, 1'b0);  // tie d=1/d=3, cost == cfg
    send(8'hF0, 32'hF200F10F, 4'd0, 2'd1, 4'd1, 1'b1);  // same, cfg 0 rejects
    send(8'h00, 32'hFFFFFFFF, 4'd8, 2'd0, 4'd8, 1'b0);  // full-width cost, no saturation
    send(8'h00, 32'hFFFFFFFF, 4'd7, 2'd0, 4'd8, 1'b1);
    send(8'h3C, 32'h3CC3FF00, 4'd2, 2'd3, 4'd0, 1'b0);  // winner at top index
    drain();

    // Back-to-back random beats against a toggling ready_out.
    lat_mode = 1'b0;
    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      l = 8'($urandom);
      r = $urandom;
      c = 4'($urandom_range(0, 8));
      model(l, r, c, md, mc, mr);
      send(l, r, c, md, mc, mr);
    end
    drain();
    bp_mode = 1'b0;
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full throughput: 20 beats must leave as one unbroken run of 20.
    lat_mode = 1'b1;
    max_run = 0;
    for (int i = 0; i < 20; i++) begin
      l = 8'($urandom);
      r = $urandom;
      c = 4'($urandom_range(0, 8));
      model(l, r, c, md, mc, mr);
      send(l, r, c, md, mc, mr);
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    check_val("tput_run", 32'(max_run), 20);

    // Mid-stream reset with three beats in flight and a beat offered during reset.
    for (int i = 0; i < 3; i++) begin
      l = 8'($urandom);
      r = $urandom;
      model(l, r, 4'd8, md, mc, mr);
      send(l, r, 4'd8, md, mc, mr);
    end
    rst = 1'b1;
    valid_in = 1'b1;
    census_left = 8'h12;
    census_right = 32'h12345678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check_val("midrst_valid_out", 32'(valid_out), 0);
    check_val("midrst_best_disp", 32'(best_disp), 0);
    check_val("midrst_min_cost", 32'(min_cost), 0);
    check_val("midrst_disp_reject", 32'(disp_reject), 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(8'h55, 32'hFF0055AA, 4'd8, 2'd1, 4'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
